// File: rtl/vlsu_pkg.sv
// Shared types for the VLSU request scheduler: FSM states, request class, default payload.
package vlsu_pkg;

  typedef logic vlsu_req_t;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    ST,
    DRAIN_TO_LD,
    DRAIN_TO_ST
  } sched_state_e;

  typedef enum logic {
    LOAD,
    STORE
  } sched_class_e;

endpackage

// File: rtl/vlsu_req_sched_outstanding_cnt.sv
// Saturating up/down counter of in-flight requests for one class, with full flag.
module vlsu_outstanding_cnt #(
  parameter int unsigned Max = 4,
  parameter int unsigned W   = $clog2(Max + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (inc_i && !dec_i) begin
      r_cnt <= r_cnt + W'(1);
    end else if (dec_i && !inc_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // A retire pulse with nothing outstanding means upstream lost track.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(dec_i && !inc_i && (r_cnt == '0)))
        else $warning("vlsu_outstanding_cnt: done pulse with zero outstanding");
    end
  end

  assign cnt_o  = r_cnt;
  assign full_o = (r_cnt == W'(Max));

endmodule

// File: rtl/vlsu_req_sched.sv
// Load/store request scheduler feeding the VLSU control machine's single request port.
// Optional performance counters enabled by defining VLSU_REQ_SCHED_PERF_EN.
module vlsu_req_sched
  import vlsu_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned MaxBurst       = 8,
  parameter type         vlsu_req_t     = vlsu_pkg::vlsu_req_t,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ld_req_valid_i,
  output logic            ld_req_ready_o,
  input  vlsu_req_t       ld_req_i,
  input  logic            st_req_valid_i,
  output logic            st_req_ready_o,
  input  vlsu_req_t       st_req_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output vlsu_req_t       req_o,
  output logic            req_is_store_o,
  input  logic            ld_done_i,
  input  logic            st_done_i,
  output logic [CntW-1:0] ld_cnt_o,
  output logic [CntW-1:0] st_cnt_o,
`ifdef VLSU_REQ_SCHED_PERF_EN
  output logic [31:0]     perf_switch_cnt_o,
  output logic [31:0]     perf_stall_cnt_o,
`endif
  output logic            idle_o
);

  localparam int unsigned BurstW = $clog2(MaxBurst + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MaxBurst);

  sched_state_e      r_state, w_next;
  logic [BurstW-1:0] r_burst;
  sched_class_e      r_rr;
  logic              r_valid;
  vlsu_req_t         r_req;
  sched_class_e      r_cls;

  logic w_ld_full, w_st_full;
  logic w_can_load, w_ld_ok, w_st_ok;
  logic w_ld_gnt, w_st_gnt, w_gnt;

  vlsu_outstanding_cnt #(.Max(MaxOutstanding), .W(CntW)) u_ld_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_ld_gnt),
    .dec_i  (ld_done_i),
    .cnt_o  (ld_cnt_o),
    .full_o (w_ld_full)
  );

  vlsu_outstanding_cnt #(.Max(MaxOutstanding), .W(CntW)) u_st_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_st_gnt),
    .dec_i  (st_done_i),
    .cnt_o  (st_cnt_o),
    .full_o (w_st_full)
  );

  assign w_can_load = !r_valid || req_ready_i;
  // Readies are held low while reset is asserted, not only after it.
  assign w_ld_ok    = rst_ni && ld_req_valid_i && !w_ld_full && w_can_load;
  assign w_st_ok    = rst_ni && st_req_valid_i && !w_st_full && w_can_load;

  always_comb begin
    w_next   = r_state;
    w_ld_gnt = 1'b0;
    w_st_gnt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ld_ok && w_st_ok) begin
          if (r_rr == STORE) w_st_gnt = 1'b1;
          else               w_ld_gnt = 1'b1;
        end else begin
          w_ld_gnt = w_ld_ok;
          w_st_gnt = w_st_ok;
        end
        if (w_ld_gnt)      w_next = LD;
        else if (w_st_gnt) w_next = ST;
      end
      LD: begin
        if (st_req_valid_i && ((r_burst == BurstMax) || !ld_req_valid_i)) begin
          w_next = DRAIN_TO_ST;
        end else begin
          w_ld_gnt = w_ld_ok;
          if (!ld_req_valid_i && !st_req_valid_i && (ld_cnt_o == '0) && !r_valid) w_next = IDLE;
        end
      end
      ST: begin
        if (ld_req_valid_i && ((r_burst == BurstMax) || !st_req_valid_i)) begin
          w_next = DRAIN_TO_LD;
        end else begin
          w_st_gnt = w_st_ok;
          if (!ld_req_valid_i && !st_req_valid_i && (st_cnt_o == '0) && !r_valid) w_next = IDLE;
        end
      end
      DRAIN_TO_LD: begin
        if ((st_cnt_o == '0) && !r_valid) begin
          w_next   = LD;
          w_ld_gnt = w_ld_ok;
        end
      end
      DRAIN_TO_ST: begin
        if ((ld_cnt_o == '0) && !r_valid) begin
          w_next   = ST;
          w_st_gnt = w_st_ok;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_gnt = w_ld_gnt || w_st_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_burst <= '0;
      r_rr    <= LOAD;
      r_valid <= 1'b0;
      r_req   <= '0;
      r_cls   <= LOAD;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_burst <= '0;
      end else if (((r_state == LD) || (r_state == ST)) && w_gnt && (r_burst != BurstMax)) begin
        r_burst <= r_burst + BurstW'(1);
      end
      if ((r_state == IDLE) && w_gnt) r_rr <= (r_rr == LOAD) ? STORE : LOAD;
      if (w_gnt) begin
        r_valid <= 1'b1;
        r_req   <= w_ld_gnt ? ld_req_i : st_req_i;
        r_cls   <= w_ld_gnt ? LOAD : STORE;
      end else if (req_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef VLSU_REQ_SCHED_PERF_EN
  logic [31:0] r_perf_switch, r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_switch <= '0;
      r_perf_stall  <= '0;
    end else begin
      if ((w_next != r_state) && ((w_next == DRAIN_TO_LD) || (w_next == DRAIN_TO_ST)))
        r_perf_switch <= r_perf_switch + 32'd1;
      if ((ld_req_valid_i || st_req_valid_i) && !w_gnt)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_switch_cnt_o = r_perf_switch;
  assign perf_stall_cnt_o  = r_perf_stall;
`endif

  assign ld_req_ready_o = w_ld_gnt;
  assign st_req_ready_o = w_st_gnt;
  assign req_valid_o    = r_valid;
  assign req_o          = r_req;
  assign req_is_store_o = (r_cls == STORE);
  assign idle_o         = (r_state == IDLE) && !r_valid && (ld_cnt_o == '0) && (st_cnt_o == '0);

endmodule

// File: tb/tb_vlsu_req_sched.sv
// Self-checking bench for vlsu_req_sched: vector table, directed corner sequences, random vs. model.
module tb_vlsu_req_sched;

  localparam int MAXO = 4;
  localparam int MAXB = 8;
  typedef logic [15:0] req_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ld_req_valid_i, st_req_valid_i, req_ready_i, ld_done_i, st_done_i;
  req_t       ld_req_i, st_req_i, req_o;
  logic       ld_req_ready_o, st_req_ready_o, req_valid_o, req_is_store_o, idle_o;
  logic [2:0] ld_cnt_o, st_cnt_o;
`ifdef VLSU_REQ_SCHED_PERF_EN
  logic [31:0] perf_switch_cnt_o, perf_stall_cnt_o;
`endif

  vlsu_req_sched #(
    .MaxOutstanding (MAXO),
    .MaxBurst       (MAXB),
    .vlsu_req_t     (req_t)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .ld_req_valid_i    (ld_req_valid_i),
    .ld_req_ready_o    (ld_req_ready_o),
    .ld_req_i          (ld_req_i),
    .st_req_valid_i    (st_req_valid_i),
    .st_req_ready_o    (st_req_ready_o),
    .st_req_i          (st_req_i),
    .req_valid_o       (req_valid_o),
    .req_ready_i       (req_ready_i),
    .req_o             (req_o),
    .req_is_store_o    (req_is_store_o),
    .ld_done_i         (ld_done_i),
    .st_done_i         (st_done_i),
    .ld_cnt_o          (ld_cnt_o),
    .st_cnt_o          (st_cnt_o),
`ifdef VLSU_REQ_SCHED_PERF_EN
    .perf_switch_cnt_o (perf_switch_cnt_o),
    .perf_stall_cnt_o  (perf_stall_cnt_o),
`endif
    .idle_o            (idle_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: class index 0 = load, 1 = store; dir -1 = no direction owned.
  int          m_cnt[2];
  bit          m_ov;
  req_t        m_op;
  bit          m_ois;
  int          m_dir;
  bit          m_drain;
  int          m_streak;
  int          m_pref;
  int unsigned m_sw, m_stall;
  bit          m_g0, m_g1;
  logic        a_lr, a_sr;

  typedef struct {
    bit lv, sv, rr, ldd, sdd;
    bit exp_lr, exp_sr;
    int exp_lc, exp_sc;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_ov = 0; m_op = '0; m_ois = 0;
    m_dir = -1; m_drain = 0; m_streak = 0; m_pref = 0;
    m_sw = 0; m_stall = 0;
  endtask

  task automatic drive_idle();
    ld_req_valid_i = 0; st_req_valid_i = 0; req_ready_i = 0;
    ld_done_i = 0; st_done_i = 0; ld_req_i = '0; st_req_i = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_valid"}, req_valid_o, 0);
    chk({tag, "_req_o"}, req_o, 0);
    chk({tag, "_is_store"}, req_is_store_o, 0);
    chk({tag, "_ld_ready"}, ld_req_ready_o, 0);
    chk({tag, "_st_ready"}, st_req_ready_o, 0);
    chk({tag, "_ld_cnt"}, ld_cnt_o, 0);
    chk({tag, "_st_cnt"}, st_cnt_o, 0);
    chk({tag, "_idle"}, idle_o, 1);
`ifdef VLSU_REQ_SCHED_PERF_EN
    chk({tag, "_perf_switch"}, perf_switch_cnt_o, 0);
    chk({tag, "_perf_stall"}, perf_stall_cnt_o, 0);
`endif
  endtask

  task automatic do_reset(input string tag);
    rst_ni = 0;
    #1;
    chk_reset_vals(tag);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    drive_idle();
    rst_ni = 1;
    m_reset();
  endtask

  task automatic step(input bit lv, input bit sv, input bit rr, input bit ldd, input bit sdd);
    bit   v[2], d[2], ok[2], g[2];
    bit   can, ndr, chg;
    int   nd, o, n;
    req_t pay[2];
    v[0] = lv; v[1] = sv; d[0] = ldd; d[1] = sdd;
    pay[0] = req_t'($urandom); pay[1] = req_t'($urandom);
    ld_req_valid_i = lv; st_req_valid_i = sv; req_ready_i = rr;
    ld_done_i = ldd; st_done_i = sdd;
    ld_req_i = pay[0]; st_req_i = pay[1];
    #1;
    can = !m_ov || rr;
    for (int c = 0; c < 2; c++) begin
      ok[c] = v[c] && (m_cnt[c] < MAXO) && can;
      g[c]  = 0;
    end
    nd = m_dir; ndr = m_drain;
    if (m_dir < 0) begin
      if (ok[0] && ok[1]) g[m_pref] = 1;
      else if (ok[0])     g[0] = 1;
      else if (ok[1])     g[1] = 1;
      if (g[0]) nd = 0;
      else if (g[1]) nd = 1;
    end else if (m_drain) begin
      o = 1 - m_dir;
      if (m_cnt[o] == 0 && !m_ov) begin
        ndr = 0;
        g[m_dir] = ok[m_dir];
      end
    end else begin
      o = 1 - m_dir;
      if (v[o] && (m_streak == MAXB || !v[m_dir])) begin
        nd = o; ndr = 1;
      end else begin
        g[m_dir] = ok[m_dir];
        if (!v[0] && !v[1] && m_cnt[m_dir] == 0 && !m_ov) nd = -1;
      end
    end
    chg = (nd != m_dir) || (ndr != m_drain);
    a_lr = ld_req_ready_o; a_sr = st_req_ready_o;
    chk("ld_ready", ld_req_ready_o, g[0]);
    chk("st_ready", st_req_ready_o, g[1]);
    @(posedge clk_i);
    #1;
    if (chg) m_streak = 0;
    else if (m_dir >= 0 && !m_drain && (g[0] || g[1]) && m_streak < MAXB) m_streak++;
    if (m_dir < 0 && (g[0] || g[1])) m_pref = 1 - m_pref;
    if (ndr && !m_drain) m_sw++;
    if ((v[0] || v[1]) && !(g[0] || g[1])) m_stall++;
    for (int c = 0; c < 2; c++) begin
      n = m_cnt[c] + int'(g[c]) - int'(d[c]);
      m_cnt[c] = (n < 0) ? 0 : n;
    end
    if (g[0] || g[1]) begin
      m_ov = 1; m_ois = g[1]; m_op = g[1] ? pay[1] : pay[0];
    end else if (rr) begin
      m_ov = 0;
    end
    m_dir = nd; m_drain = ndr;
    m_g0 = g[0]; m_g1 = g[1];
    chk("req_valid", req_valid_o, m_ov);
    if (m_ov) begin
      chk("req_o", req_o, m_op);
      chk("req_is_store", req_is_store_o, m_ois);
    end
    chk("ld_cnt", ld_cnt_o, m_cnt[0]);
    chk("st_cnt", st_cnt_o, m_cnt[1]);
    chk("idle", idle_o, (m_dir < 0) && !m_ov && m_cnt[0] == 0 && m_cnt[1] == 0);
`ifdef VLSU_REQ_SCHED_PERF_EN
    chk("perf_switch", perf_switch_cnt_o, m_sw);
    chk("perf_stall", perf_stall_cnt_o, m_stall);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t held;
    int   first_st, lds;
    rst_ni = 0;
    drive_idle();
    m_reset();
    do_reset("rst0");

    // Both valid out of reset: load wins, next IDLE arbitration goes to the store.
    step(1, 1, 1, 0, 0);
    chk("rr_first_is_load", {a_lr, a_sr}, 2'b10);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("back_to_idle", idle_o, 1);
    step(1, 1, 1, 0, 0);
    chk("rr_second_is_store", {a_lr, a_sr}, 2'b01);

    // Vector table: outstanding limit, retire-then-accept, simultaneous grant+retire, underflow.
    do_reset("rst1");
    tbl.push_back('{1, 0, 1, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 1, 0, 2, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 1, 0, 3, 0});
    tbl.push_back('{1, 0, 1, 1, 0, 1, 0, 3, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 1, 0, 4, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 4, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 4, 0});
    tbl.push_back('{1, 0, 1, 1, 0, 0, 0, 3, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 1, 0, 4, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 0, 3, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 0, 2, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 1, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      step(tbl[i].lv, tbl[i].sv, tbl[i].rr, tbl[i].ldd, tbl[i].sdd);
      chk($sformatf("tbl%0d_ld_ready", i), a_lr, tbl[i].exp_lr);
      chk($sformatf("tbl%0d_st_ready", i), a_sr, tbl[i].exp_sr);
      chk($sformatf("tbl%0d_ld_cnt", i), ld_cnt_o, tbl[i].exp_lc);
      chk($sformatf("tbl%0d_st_cnt", i), st_cnt_o, tbl[i].exp_sc);
    end

    // Backpressure: payload must hold and nothing new accepted.
    do_reset("rst2");
    step(1, 0, 0, 0, 0);
    held = req_o;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0);
      chk("bp_hold_req", req_o, held);
      chk("bp_no_ready", a_lr, 0);
      chk("bp_ld_cnt", ld_cnt_o, 1);
    end
    step(1, 0, 1, 0, 0);

    // Burst bound: 1 IDLE grant + MaxBurst LD grants, then store after loads retire.
    do_reset("rst3");
    first_st = -1; lds = 0;
    for (int i = 0; i < 14; i++) begin
      step(1, 1, 1, m_cnt[0] > 0, 0);
      if (m_g1 && first_st < 0) first_st = i;
      if (m_g0 && first_st < 0) lds++;
    end
    chk("burst_loads_before_store", lds, MAXB + 1);
    chk("burst_first_store_cycle", first_st, MAXB + 2);

    // Reset while draining toward stores with two loads outstanding.
    do_reset("rst4");
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("drain_ld_cnt", ld_cnt_o, 2);
    chk("drain_no_store", a_sr, 0);
    st_req_valid_i = 1;
    do_reset("rst_mid");

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
           (m_cnt[0] > 0) && (($urandom % 3) == 0),
           (m_cnt[1] > 0) && (($urandom % 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
